fetch_unit: RTL and testbench

- IF stage of the pipelined TSC core. It is the consumer of the hazard unit's stall, flush and count outputs, and the initiator on the instruction-memory port.
- Owns PC, IR, the in-flight request address and a one-word hold buffer.
- Delivers one instruction per cycle to ID when memory is zero-wait.
- Obeys pc_write / ir_write / flush_if, applies redirects, and maintains num_inst.

---
 rtl/fetch_unit_pkg.sv | 16 +
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and state encoding for the IF stage
package fetch_unit_pkg;

   localparam int WORD_SIZE = 16;

   // RTYPE with func 6'h3F: the decoder treats it as no control
   localparam logic [15:0] INST_NOP = 16'hF03F;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2,
      S_HALT  = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: PC/IR, memory request FSM, hold buffer, counters
// Optional memory-bubble counter output num_bubble under FETCH_BUBBLE_CNT_EN.
module fetch_unit #(
   parameter int               WORD_SIZE = 16,
   parameter logic [15:0]      RESET_PC  = 16'h0000
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 i_readM,
   output logic [WORD_SIZE-1:0] i_address,
   input  logic [WORD_SIZE-1:0] i_data,
   input  logic                 i_ready,
   input  logic                 pc_write,
   input  logic                 ir_write,
   input  logic                 flush_if,
   input  logic                 incr_num_inst,
   input  logic                 redirect,
   input  logic [WORD_SIZE-1:0] redirect_pc,
   input  logic                 halt,
   output logic [WORD_SIZE-1:0] ir,
   output logic [WORD_SIZE-1:0] pc_id,
   output logic [WORD_SIZE-1:0] pc_plus1_id,
   output logic [WORD_SIZE-1:0] num_inst
`ifdef FETCH_BUBBLE_CNT_EN
   ,
   output logic [WORD_SIZE-1:0] num_bubble
`endif
);

   import fetch_unit_pkg::*;

   fetch_state_t         r_state, w_state_n;
   logic [WORD_SIZE-1:0] r_pc, w_pc_n;
   logic [WORD_SIZE-1:0] r_req_addr, w_req_n;
   logic [WORD_SIZE-1:0] r_ir, w_ir_n;
   logic [WORD_SIZE-1:0] r_pc_id, w_pc_id_n;
   logic [WORD_SIZE-1:0] r_hold, w_hold_n;
   logic                 r_halt_pend, w_halt_pend_n;
   logic [WORD_SIZE-1:0] r_num_inst;
   logic                 w_advance;
   logic                 w_inflight;

   assign w_advance  = pc_write & ir_write;
   assign w_inflight = (r_state == S_REQ) || (r_state == S_DRAIN);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_req_addr  <= RESET_PC;
         r_ir        <= INST_NOP;
         r_pc_id     <= '0;
         r_hold      <= '0;
         r_halt_pend <= 1'b0;
      end else begin
         r_state     <= w_state_n;
         r_pc        <= w_pc_n;
         r_req_addr  <= w_req_n;
         r_ir        <= w_ir_n;
         r_pc_id     <= w_pc_id_n;
         r_hold      <= w_hold_n;
         r_halt_pend <= w_halt_pend_n;
      end
   end

   always_comb begin
      w_state_n     = r_state;
      w_pc_n        = r_pc;
      w_req_n       = r_req_addr;
      w_ir_n        = r_ir;
      w_pc_id_n     = r_pc_id;
      w_hold_n      = r_hold;
      w_halt_pend_n = r_halt_pend;
      if (r_state == S_HALT) begin
         w_ir_n = INST_NOP;
      end else if (redirect) begin
         // An unfinished request must complete before the new address is issued
         w_pc_n        = redirect_pc;
         w_ir_n        = INST_NOP;
         w_halt_pend_n = 1'b0;
         if (w_inflight && !i_ready) begin
            w_state_n = S_DRAIN;
         end else begin
            w_req_n   = redirect_pc;
            w_state_n = S_REQ;
         end
      end else if (r_state == S_DRAIN) begin
         w_ir_n = INST_NOP;
         if (halt && !flush_if)
            w_halt_pend_n = 1'b1;
         if (i_ready) begin
            w_req_n   = r_pc;
            w_state_n = (r_halt_pend || (halt && !flush_if)) ? S_HALT : S_REQ;
         end
      end else if (flush_if) begin
         w_ir_n = INST_NOP;
      end else if (halt) begin
         w_ir_n = INST_NOP;
         if (r_state == S_REQ && !i_ready) begin
            w_state_n     = S_DRAIN;
            w_halt_pend_n = 1'b1;
         end else begin
            w_state_n = S_HALT;
         end
      end else if (r_state == S_REQ) begin
         if (i_ready && w_advance) begin
            w_ir_n    = i_data;
            w_pc_id_n = r_pc;
            w_pc_n    = r_pc + 1'b1;
            w_req_n   = r_pc + 1'b1;
         end else if (i_ready) begin
            w_hold_n  = i_data;
            w_state_n = S_HOLD;
         end else if (w_advance) begin
            w_ir_n = INST_NOP;
         end
      end else if (w_advance) begin
         w_ir_n    = r_hold;
         w_pc_id_n = r_pc;
         w_pc_n    = r_pc + 1'b1;
         w_req_n   = r_pc + 1'b1;
         w_state_n = S_REQ;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_num_inst <= '0;
      else if (incr_num_inst)
         r_num_inst <= r_num_inst + 1'b1;
   end

`ifdef FETCH_BUBBLE_CNT_EN
   logic [WORD_SIZE-1:0] r_num_bubble;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_num_bubble <= '0;
      else if (r_state == S_REQ && w_advance && !i_ready && !redirect && !flush_if)
         r_num_bubble <= r_num_bubble + 1'b1;
   end

   assign num_bubble = r_num_bubble;
`endif

`ifndef SYNTHESIS
   a_hazard_match: assert property (@(posedge clk) disable iff (reset) pc_write == ir_write);
`endif

   assign i_readM     = !reset && w_inflight;
   assign i_address   = r_req_addr;
   assign ir          = r_ir;
   assign pc_id       = r_pc_id;
   assign pc_plus1_id = r_pc_id + 1'b1;
   assign num_inst    = r_num_inst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a latency-programmable memory
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        i_readM;
   logic [15:0] i_address;
   logic [15:0] i_data = '0;
   logic        i_ready = 1'b0;
   logic        pc_write = 1'b1;
   logic        ir_write = 1'b1;
   logic        flush_if = 1'b0;
   logic        incr_num_inst = 1'b1;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = '0;
   logic        halt = 1'b0;
   logic [15:0] ir;
   logic [15:0] pc_id;
   logic [15:0] pc_plus1_id;
   logic [15:0] num_inst;
`ifdef FETCH_BUBBLE_CNT_EN
   logic [15:0] num_bubble;
`endif

   fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .i_readM(i_readM), .i_address(i_address),
      .i_data(i_data), .i_ready(i_ready), .pc_write(pc_write), .ir_write(ir_write),
      .flush_if(flush_if), .incr_num_inst(incr_num_inst), .redirect(redirect),
      .redirect_pc(redirect_pc), .halt(halt), .ir(ir), .pc_id(pc_id),
      .pc_plus1_id(pc_plus1_id), .num_inst(num_inst)
`ifdef FETCH_BUBBLE_CNT_EN
      , .num_bubble(num_bubble)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int lat = 1;
   int wcnt = 0;
   bit sb_en = 1'b0;

   typedef struct {
      logic [15:0] addr;
      logic [15:0] data;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic        adv;
      logic        flush;
      logic        incr;
      logic        rdm;
      logic [15:0] addr;
      logic [15:0] ir;
      logic [15:0] pcid;
      logic [15:0] ninst;
   } vec_t;
   vec_t tbl[14];

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      if (a == 16'h0005) return 16'h1234;
      return a + 16'h1000;
   endfunction

   // Memory answers on the lat-th cycle of each request; decided at negedge
   always @(negedge clk) begin
      sb_t e;
      if (reset || !i_readM) begin
         i_ready = 1'b0;
         wcnt = 0;
      end else if (wcnt >= lat - 1) begin
         i_ready = 1'b1;
         i_data = mem_f(i_address);
         wcnt = 0;
         if (sb_en) begin
            e.addr = i_address;
            e.data = i_data;
            sb_q.push_back(e);
         end
      end else begin
         i_ready = 1'b0;
         wcnt++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      pc_write = 1'b1; ir_write = 1'b1; flush_if = 1'b0; halt = 1'b0;
      redirect = 1'b0; incr_num_inst = 1'b1;
      step();
      chk("rst_readM", i_readM, 0);
      chk("rst_addr", i_address, 16'h0000);
      chk("rst_ir", ir, INST_NOP);
      chk("rst_pc_id", pc_id, 0);
      chk("rst_num_inst", num_inst, 0);
`ifdef FETCH_BUBBLE_CNT_EN
      chk("rst_num_bubble", num_bubble, 0);
`endif
      step();
      reset = 1'b0;
   endtask

   initial begin
      int words;
      int n;
      sb_t e;

      tbl[0]  = '{1, 0, 1, 1, 16'd1,  16'h1000, 16'd0, 16'd1};
      tbl[1]  = '{1, 0, 1, 1, 16'd2,  16'h1001, 16'd1, 16'd2};
      tbl[2]  = '{1, 0, 1, 1, 16'd3,  16'h1002, 16'd2, 16'd3};
      tbl[3]  = '{1, 0, 1, 1, 16'd4,  16'h1003, 16'd3, 16'd4};
      tbl[4]  = '{1, 0, 1, 1, 16'd5,  16'h1004, 16'd4, 16'd5};
      tbl[5]  = '{0, 0, 1, 0, 16'd5,  16'h1004, 16'd4, 16'd6};
      tbl[6]  = '{0, 0, 0, 0, 16'd5,  16'h1004, 16'd4, 16'd6};
      tbl[7]  = '{0, 0, 0, 0, 16'd5,  16'h1004, 16'd4, 16'd6};
      tbl[8]  = '{1, 0, 1, 1, 16'd6,  16'h1234, 16'd5, 16'd7};
      tbl[9]  = '{1, 0, 1, 1, 16'd7,  16'h1006, 16'd6, 16'd8};
      tbl[10] = '{1, 0, 1, 1, 16'd8,  16'h1007, 16'd7, 16'd9};
      tbl[11] = '{1, 0, 1, 1, 16'd9,  16'h1008, 16'd8, 16'd10};
      tbl[12] = '{1, 1, 1, 1, 16'd9,  16'hF03F, 16'd8, 16'd11};
      tbl[13] = '{1, 0, 1, 1, 16'd10, 16'h1009, 16'd9, 16'd12};

      // zero-wait stream, stall into hold buffer, flush re-fetch
      lat = 1;
      do_reset();
      for (int i = 0; i < 14; i++) begin
         pc_write = tbl[i].adv;
         ir_write = tbl[i].adv;
         flush_if = tbl[i].flush;
         incr_num_inst = tbl[i].incr;
         step();
         chk($sformatf("tbl%0d_readM", i), i_readM, tbl[i].rdm);
         chk($sformatf("tbl%0d_addr", i), i_address, tbl[i].addr);
         chk($sformatf("tbl%0d_ir", i), ir, tbl[i].ir);
         chk($sformatf("tbl%0d_pc_id", i), pc_id, tbl[i].pcid);
         chk($sformatf("tbl%0d_num_inst", i), num_inst, tbl[i].ninst);
      end
      flush_if = 1'b0;
      incr_num_inst = 1'b1;
      chk("pc_plus1_id", pc_plus1_id, 16'd10);

      // 3-cycle memory: scoreboard of returned words against delivered ir
      do_reset();
      lat = 3;
      sb_en = 1'b1;
      words = 0;
      for (int c = 1; c <= 12; c++) begin
         step();
         if (ir != INST_NOP) begin
            chk("sb_has_entry", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("sb_ir", ir, e.data);
               chk("sb_pc_id", pc_id, e.addr);
               words++;
            end
         end
         chk($sformatf("lat_pattern_c%0d", c), ir != INST_NOP, (c % 3) == 0);
      end
      sb_en = 1'b0;
      chk("lat_words", words, 4);
      chk("sb_drained", sb_q.size(), 0);
`ifdef FETCH_BUBBLE_CNT_EN
      chk("num_bubble", num_bubble, 8);
`endif

      // halt while a slow request is in flight
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt_inflight_readM", i_readM, 1);
      chk("halt_ir", ir, INST_NOP);
      n = 0;
      while (i_readM && n < 6) begin
         step();
         n++;
      end
      chk("halt_cycles", n, 2);
      repeat (2) step();
      chk("halted_readM", i_readM, 0);
      chk("halted_ir", ir, INST_NOP);

      // redirect during a pending request: drain then fetch target
      lat = 1;
      do_reset();
      repeat (7) step();
      chk("pre_redir_addr", i_address, 16'd7);
      lat = 3;
      redirect = 1'b1;
      redirect_pc = 16'h0040;
      step();
      redirect = 1'b0;
      chk("drain_addr0", i_address, 16'd7);
      chk("drain_readM", i_readM, 1);
      chk("drain_ir0", ir, INST_NOP);
      step();
      chk("drain_addr1", i_address, 16'd7);
      chk("drain_ir1", ir, INST_NOP);
      step();
      chk("drain_done_addr", i_address, 16'h0040);
      chk("drain_done_ir", ir, INST_NOP);
      lat = 1;
      step();
      chk("redir_ir", ir, 16'h1040);
      chk("redir_pc_id", pc_id, 16'h0040);
      chk("redir_pc_plus1", pc_plus1_id, 16'h0041);

      // redirect with a word arriving the same cycle, then PC wrap
      redirect = 1'b1;
      redirect_pc = 16'hFFFF;
      step();
      redirect = 1'b0;
      chk("redir_drop_ir", ir, INST_NOP);
      chk("redir_drop_addr", i_address, 16'hFFFF);
      step();
      chk("wrap_ir", ir, 16'h0FFF);
      chk("wrap_pc_id", pc_id, 16'hFFFF);
      chk("wrap_pc_plus1", pc_plus1_id, 16'h0000);
      chk("wrap_addr", i_address, 16'h0000);
      step();
      chk("wrap_next_pc_id", pc_id, 16'h0000);
      chk("wrap_next_ir", ir, 16'h1000);

      // halt with zero-wait memory
      halt = 1'b1;
      step();
      halt = 1'b0;
      chk("halt0_readM", i_readM, 0);
      chk("halt0_ir", ir, INST_NOP);
      step();
      chk("halt0_stay", i_readM, 0);

      // asynchronous reset in the middle of a drain
      do_reset();
      lat = 3;
      step();
      redirect = 1'b1;
      redirect_pc = 16'h0080;
      step();
      redirect = 1'b0;
      chk("pre_areset_readM", i_readM, 1);
      chk("pre_areset_addr", i_address, 16'h0000);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_readM", i_readM, 0);
      chk("areset_addr", i_address, 16'h0000);
      chk("areset_ir", ir, INST_NOP);
      chk("areset_pc_id", pc_id, 0);
      chk("areset_num_inst", num_inst, 0);
      lat = 1;
      step();
      reset = 1'b0;
      step();
      chk("post_areset_ir", ir, 16'h1000);
      chk("post_areset_pc_id", pc_id, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
